pq_search_ctrl: RTL and testbench

//  Sequential trial-division controller for the RSA key path. Accepts a 14-bit

---
 rtl/pq_pkg.sv | 26 ++
 rtl/pq_seq_div.sv | 89 ++++++++
 rtl/pq_search_ctrl.sv | 144 ++++++++++++++
 tb/tb_pq_search_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared widths, prime table and FSM encoding for the trial-division
// factor search and its iterative divider.
package pq_pkg;

  localparam int N_W        = 14;
  localparam int P_W        = 7;
  localparam int NUM_PRIMES = 31;
  localparam int IDX_W      = 5;
  localparam int CNT_W      = 4;

  localparam logic [P_W-1:0] PRIMES [0:NUM_PRIMES-1] = '{
    7'd2,   7'd3,   7'd5,   7'd7,   7'd11,  7'd13,  7'd17,  7'd19,
    7'd23,  7'd29,  7'd31,  7'd37,  7'd41,  7'd43,  7'd47,  7'd53,
    7'd59,  7'd61,  7'd67,  7'd71,  7'd73,  7'd79,  7'd83,  7'd89,
    7'd97,  7'd101, 7'd103, 7'd107, 7'd109, 7'd113, 7'd127
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIV   = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/pq_seq_div.sv
// Restoring divider, one quotient bit per cycle. The first step is taken on
// the start edge so valid pulses exactly N_W cycles after start.
module pq_seq_div
  import pq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [P_W-1:0] divisor,
  output logic [N_W-1:0] quot,
  output logic [P_W-1:0] rem,
  output logic           valid
);

  logic [P_W-1:0]   rem_q, rem_d;
  logic [N_W-1:0]   quot_q, quot_d;
  logic [P_W-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             valid_q, valid_d;

  logic [P_W-1:0] src_rem;
  logic [N_W-1:0] src_quot;
  logic [P_W-1:0] src_dsr;
  logic [P_W:0]   trial;
  logic [P_W:0]   diff;
  logic           ge;

  // quot_q carries the unconsumed dividend bits at the top and the
  // developed quotient bits at the bottom.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quot = start ? dividend : quot_q;
    src_dsr  = start ? divisor : dsr_q;
    trial    = {src_rem, src_quot[N_W-1]};
    diff     = trial - {1'b0, src_dsr};
    ge       = (trial >= {1'b0, src_dsr});
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    valid_d = 1'b0;
    if (start || run_q) begin
      rem_d  = ge ? diff[P_W-1:0] : trial[P_W-1:0];
      quot_d = {src_quot[N_W-2:0], ge};
      dsr_d  = src_dsr;
    end
    if (start) begin
      cnt_d = CNT_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(N_W - 1)) begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quot_q  <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign quot  = quot_q;
  assign rem   = rem_q;
  assign valid = valid_q;

endmodule

// File: rtl/pq_search_ctrl.sv
// Smallest-prime-factor search: walks the prime table in ascending order,
// one shared divider trial per prime, and reports p and q = n/p.
module pq_search_ctrl
  import pq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [P_W-1:0] p,
  output logic [N_W-1:0] q
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [P_W-1:0]   res_p_q, res_p_d;
  logic [N_W-1:0]   res_q_q, res_q_d;
  logic             res_found_q, res_found_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [N_W-1:0]   q_q, q_d;
  logic             found_q, found_d;
  logic             done_q, done_d;
  logic             div_start_q, div_start_d;

  logic [P_W-1:0] cur_prime;
  logic [N_W-1:0] div_quot;
  logic [P_W-1:0] div_rem;
  logic           div_valid;

  assign cur_prime = PRIMES[idx_q];

  pq_seq_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_q),
    .dividend (n_q),
    .divisor  (cur_prime),
    .quot     (div_quot),
    .rem      (div_rem),
    .valid    (div_valid)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    res_p_d     = res_p_q;
    res_q_d     = res_q_q;
    res_found_d = res_found_q;
    p_d         = p_q;
    q_d         = q_q;
    found_d     = found_q;
    done_d      = 1'b0;
    div_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n;
          state_d = LOAD;
        end
      end
      LOAD: begin
        idx_d = '0;
        if (n_q < N_W'(2)) begin
          res_p_d     = '0;
          res_q_d     = '0;
          res_found_d = 1'b0;
          state_d     = FIN;
        end else begin
          div_start_d = 1'b1;
          state_d     = DIV;
        end
      end
      DIV: begin
        if (div_valid) state_d = CHECK;
      end
      CHECK: begin
        if (div_rem == '0) begin
          res_p_d     = cur_prime;
          res_q_d     = div_quot;
          res_found_d = 1'b1;
          state_d     = FIN;
        end else if (idx_q == IDX_W'(NUM_PRIMES - 1)) begin
          res_p_d     = '0;
          res_q_d     = '0;
          res_found_d = 1'b0;
          state_d     = FIN;
        end else begin
          idx_d       = idx_q + IDX_W'(1);
          div_start_d = 1'b1;
          state_d     = DIV;
        end
      end
      FIN: begin
        // Visible outputs only move here, so they hold across a new search.
        done_d  = 1'b1;
        p_d     = res_p_q;
        q_d     = res_q_q;
        found_d = res_found_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      res_p_q     <= '0;
      res_q_q     <= '0;
      res_found_q <= 1'b0;
      p_q         <= '0;
      q_q         <= '0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      res_p_q     <= res_p_d;
      res_q_q     <= res_q_d;
      res_found_q <= res_found_d;
      p_q         <= p_d;
      q_q         <= q_d;
      found_q     <= found_d;
      done_q      <= done_d;
      div_start_q <= div_start_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign found = found_q;
  assign p     = p_q;
  assign q     = q_q;

endmodule

// File: tb/tb_pq_search_ctrl.sv
// Directed bench for pq_search_ctrl: stimulus pushes hand-computed results
// into a queue, a negedge monitor pops and compares on every done pulse.
module tb_pq_search_ctrl;

  localparam int CLK_HALF = 5;

  typedef struct {
    int n;
    int p;
    int q;
    int found;
    int lat;
    int acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] n_in;
  logic        busy;
  logic        done;
  logic        found;
  logic [6:0]  p;
  logic [13:0] q;

  int   checks;
  int   errors;
  int   cyc;
  bit   busy_gap;
  exp_t exp_q[$];

  pq_search_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n     (n_in),
    .busy  (busy),
    .done  (done),
    .found (found),
    .p     (p),
    .q     (q)
  );

  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(CLK_HALF * 2 * 100000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() != 0 && !done && !busy) busy_gap = 1'b1;
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("p(n=%0d)", e.n), int'(p), e.p);
            check($sformatf("q(n=%0d)", e.n), int'(q), e.q);
            check($sformatf("found(n=%0d)", e.n), int'(found), e.found);
            check($sformatf("latency(n=%0d)", e.n), cyc - e.acc, e.lat);
            check($sformatf("busy_held(n=%0d)", e.n), int'(busy_gap), 0);
            busy_gap = 1'b0;
          end
        end
      end
    end
  end

  // Call at a negedge with the DUT idle; returns just after the accept edge.
  task automatic issue(input int nv, input int ep, input int eq, input int ef, input int el);
    exp_t e;
    start = 1'b1;
    n_in  = 14'(nv);
    @(posedge clk);
    #1;
    e.n = nv; e.p = ep; e.q = eq; e.found = ef; e.lat = el; e.acc = cyc;
    exp_q.push_back(e);
    start = 1'b0;
    n_in  = 14'h2aaa;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    check("result_timeout", 1, 0);
    exp_q.delete();
  endtask

  task automatic wait_done_pulse();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 1, 0);
  endtask

  task automatic run(input int nv, input int ep, input int eq, input int ef, input int el);
    wait_idle();
    issue(nv, ep, eq, ef, el);
    wait_empty();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    busy_gap = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    n_in     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_p", int'(p), 0);
    check("rst_q", int'(q), 0);
    rst_n = 1'b1;

    // n, p, q, found, latency = 2 + 16*(k+1) for first factor at index k
    run(6,     2,   3,    1, 18);
    run(143,   11,  13,   1, 82);
    run(131,   0,   0,    0, 498);
    run(127,   127, 1,    1, 498);
    run(0,     0,   0,    0, 2);
    run(1,     0,   0,    0, 2);
    run(16382, 2,   8191, 1, 18);
    run(9,     3,   3,    1, 34);
    run(16129, 127, 127,  1, 498);

    // Start while busy with a different n must be ignored.
    wait_idle();
    issue(143, 11, 13, 1, 82);
    repeat (10) @(negedge clk);
    start = 1'b1;
    n_in  = 14'd15;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (60) @(negedge clk);

    // Outputs hold the previous result (143) while a new search runs.
    issue(25, 5, 5, 1, 50);
    repeat (10) @(negedge clk);
    check("hold_p", int'(p), 11);
    check("hold_q", int'(q), 13);
    check("hold_found", int'(found), 1);
    wait_empty();

    // Back-to-back: new start issued in the done cycle of the previous one.
    wait_idle();
    issue(2, 2, 1, 1, 18);
    wait_done_pulse();
    issue(15, 3, 5, 1, 34);
    wait_done_pulse();
    issue(16383, 3, 5461, 1, 34);
    wait_empty();

    // Reset during the third trial of n=143 aborts with no done.
    wait_idle();
    issue(143, 11, 13, 1, 82);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    busy_gap = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_found", int'(found), 0);
    check("abort_p", int'(p), 0);
    check("abort_q", int'(q), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_idle", int'(busy), 0);

    run(15, 3, 5, 1, 34);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
